// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiation engine:
// state encoding, default operand width and index-width helper.
package rsa_pkg;

    localparam int DEF_WIDTH = 4096;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        SCAN   = 3'd2,
        SQUARE = 3'd3,
        MULT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic int idx_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/modmul_serial.sv
// Bit-serial interleaved A*B mod N, one bit of A (MSB first)
// per cycle, WIDTH cycles; product/done are valid in the last one.
module modmul_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDXW  = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] a_q, b_q, n_q, r_q;
    logic [IDXW-1:0]  cnt_q;
    logic             busy_q;
    logic [WIDTH+1:0] t0, t1, t2, nx;

    // One iteration: T = 2R + a_i*B, then at most two subtractions of N.
    always_comb begin
        nx = {2'b00, n_q};
        t0 = {1'b0, r_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
        t1 = (t0 >= nx) ? t0 - nx : t0;
        t2 = (t1 >= nx) ? t1 - nx : t1;
        product = t2[WIDTH-1:0];
        done = busy_q && (cnt_q == '0);
    end

    // Operand load on start, otherwise shift A and accumulate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            n_q    <= n;
            r_q    <= '0;
            cnt_q  <= IDXW'(WIDTH - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            a_q   <= a_q << 1;
            r_q   <= product;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/modexp_engine.sv
// message^exponent mod modulus, left-to-right square-and-multiply.
// MODEXP_CONST_TIME_EN: square+multiply every bit, data-independent.
module modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDXW  = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] message,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] e_q, e_d, n_q, n_d, mr_q, mr_d;
    logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             ov_q, ov_d, err_q, err_d;
    logic             mm_start, mm_done;
    logic [WIDTH-1:0] mm_a, mm_b, mm_n, mm_p;

    modmul_serial #(.WIDTH(WIDTH), .IDXW(IDXW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mm_start),
        .a       (mm_a),
        .b       (mm_b),
        .n       (mm_n),
        .done    (mm_done),
        .product (mm_p)
    );

    // Next state, multiplier launches and output staging.
    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        n_d      = n_q;
        mr_d     = mr_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        res_d    = res_q;
        ov_d     = ov_q;
        err_d    = err_q;
        mm_start = 1'b0;
        mm_a     = acc_q;
        mm_b     = acc_q;
        mm_n     = n_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                e_d = exponent;
                n_d = modulus;
                if (modulus == '0) begin
                    state_d = DONE;
                    acc_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    state_d  = REDUCE;
                    err_d    = 1'b0;
                    acc_d    = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                    mm_start = 1'b1;
                    mm_a     = message;
                    mm_b     = WIDTH'(1);
                    mm_n     = modulus;
                end
            end
            REDUCE: if (mm_done) begin
                mr_d  = mm_p;
                idx_d = IDXW'(WIDTH - 1);
`ifdef MODEXP_CONST_TIME_EN
                state_d  = SQUARE;
                mm_start = 1'b1;
`else
                state_d = SCAN;
`endif
            end
            SCAN: begin
                if (e_q[idx_q]) begin
                    state_d  = SQUARE;
                    mm_start = 1'b1;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            SQUARE: if (mm_done) begin
                acc_d = mm_p;
                mm_a  = mm_p;
                mm_b  = mm_p;
`ifdef MODEXP_CONST_TIME_EN
                state_d  = MULT;
                mm_start = 1'b1;
                mm_b     = mr_q;
`else
                if (e_q[idx_q]) begin
                    state_d  = MULT;
                    mm_start = 1'b1;
                    mm_b     = mr_q;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q - 1'b1;
                    mm_start = 1'b1;
                end
`endif
            end
            MULT: if (mm_done) begin
`ifdef MODEXP_CONST_TIME_EN
                acc_d = e_q[idx_q] ? mm_p : acc_q;
`else
                acc_d = mm_p;
`endif
                mm_a = acc_d;
                mm_b = acc_d;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d  = SQUARE;
                    idx_d    = idx_q - 1'b1;
                    mm_start = 1'b1;
                end
            end
            DONE: begin
                if (ov_q && out_ready) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                end else begin
                    ov_d  = 1'b1;
                    res_d = acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            ov_d     = 1'b0;
            mm_start = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            e_q     <= '0;
            n_q     <= '0;
            mr_q    <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            n_q     <= n_d;
            mr_q    <= mr_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign result    = res_q;
    assign error     = err_q;

endmodule

// File: tb/tb_modexp_engine.sv
// Directed-vector bench for modexp_engine at WIDTH=16.
// Honours MODEXP_CONST_TIME_EN for the expected latency.
module tb_modexp_engine;

    localparam int W     = 16;
    localparam int LIMIT = 1000;
`ifdef MODEXP_CONST_TIME_EN
    localparam int LAT_813 = 529;
`else
    localparam int LAT_813 = 142;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] message = '0;
    logic [W-1:0] exponent = '0;
    logic [W-1:0] modulus = '0;
    logic         abort = 1'b0;
    logic         busy;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         error;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    modexp_engine #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .message   (message),
        .exponent  (exponent),
        .modulus   (modulus),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .error     (error)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input int m, input int e, input int n);
        @(posedge clk); #1;
        message  = W'(m);
        exponent = W'(e);
        modulus  = W'(n);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid)
            check("out_valid_timeout", lat, -1);
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, int'(out_valid), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic run(input string tag, input int m, input int e,
                       input int n, input int exp_r, input int exp_e,
                       output int lat);
        launch(m, e, n);
        wait_out(lat);
        check({tag, "_result"}, int'(result), exp_r);
        check({tag, "_error"}, int'(error), exp_e);
        take(tag);
    endtask

    initial begin
        int lat;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_error", int'(error), 0);
        reset = 1'b1;

        run("enc", 8, 13, 77, 50, 0, lat);
        check("enc_latency", lat, LAT_813);

        run("dec", 50, 37, 77, 8, 0, lat);
        run("e0", 5, 0, 77, 1, 0, lat);
        run("n1", 5, 13, 1, 0, 0, lat);
        run("prered", 200, 1, 77, 46, 0, lat);

        launch(9, 3, 0);
        wait_out(lat);
        check("nz_latency", lat, 1);
        check("nz_error", int'(error), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("nz_hold_ov", int'(out_valid), 1);
            check("nz_hold_result", int'(result), 0);
            check("nz_hold_in_ready", int'(in_ready), 0);
        end
        take("nz");

        launch(8, 13, 77);
        repeat (19) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("abort_no_ov", seen, 0);
        run("post_abort", 8, 13, 77, 50, 0, lat);

        launch(8, 13, 77);
        message  = W'(3);
        exponent = W'(2);
        modulus  = W'(0);
        in_valid = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        check("busy_in_result", int'(result), 50);
        check("busy_in_error", int'(error), 0);
        take("busy_in");

        launch(8, 13, 77);
        repeat (39) @(posedge clk);
        #1;
        check("mid_busy", int'(busy), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_ov", int'(out_valid), 0);
        check("mid_rst_result", int'(result), 0);
        check("mid_rst_error", int'(error), 0);
        reset = 1'b1;
        run("post_rst", 50, 37, 77, 8, 0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/modexp_engine.md
Name: modexp_engine

Overview:
- Parametrised successor to the fixed 4096-bit rsa4k exponentiator: computes result = message^exponent mod modulus for any WIDTH.
- Uses a bit-serial interleaved modular multiplier and left-to-right square-and-multiply.
- Adds valid/ready handshakes on input and output, abort, error flag and leading-zero exponent skip.
- Sits between the RSA key/message register file and the output buffer.

Parameters:
- WIDTH, 4096, operand width in bits (message, exponent, modulus, result); legal range >= 8.
- IDXW, $clog2(WIDTH), width of the exponent bit index.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  engine idle, can accept operands
- message  in  WIDTH  base; any value, reduced internally
- exponent  in  WIDTH  exponent
- modulus  in  WIDTH  modulus; odd not required
- abort  in  1  cancel the current operation
- busy  out  1  high in any state except IDLE
- out_valid  out  1  result/error valid; held until taken
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  message^exponent mod modulus
- error  out  1  modulus was zero; qualified by out_valid

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; in_ready=1; busy=0; out_valid=0; result=0; error=0; all internal registers cleared. Reset overrides everything, including mid-operation.
- Accept: in_valid && in_ready at a clock edge. Latch M, E, N. This is cycle 0.
- States: IDLE, REDUCE, SCAN, SQUARE, MULT, DONE.
- IDLE -> DONE on accept when modulus==0. Sets result=0, error=1; out_valid=1 in cycle 1.
- IDLE -> REDUCE on accept otherwise.
  - REDUCE computes Mr = M*1 mod N (A=M, B=1).
  - R is initialised to (N==1) ? 0 : 1.
- Modular multiply (sub-module), one iteration per cycle, exactly WIDTH cycles:
  - Scan A MSB first. Per bit: T = 2R + a_i*B; subtract N up to twice while T >= N.
  - T is WIDTH+2 bits.
  - Valid for any A when B < N.
- REDUCE runs cycles 1..WIDTH, then -> SCAN with idx = WIDTH-1.
- SCAN: one bit per cycle.
  - E[idx]==1 -> SQUARE, keeping idx.
  - Else if idx==0 -> DONE with R (exponent 0 gives 1 mod N).
  - Else idx--.
  - Scan takes WIDTH-k cycles, where k = top set bit index of E.
- SQUARE: R = R*R mod N.
  - Then -> MULT if E[idx]==1.
  - Else -> DONE if idx==0.
  - Else idx--, -> SQUARE.
- MULT: R = R*Mr mod N. Then -> DONE if idx==0, else idx--, -> SQUARE.
- DONE: result=R, out_valid=1, error=0 (unless set by the modulus==0 path).
  - Hold result and flags until out_ready; then -> IDLE next cycle.
  - out_valid drops in that IDLE cycle.
- Latency, accept to first out_valid cycle: WIDTH + (WIDTH-k) + WIDTH*(k+1+h) + 1, where h = popcount(E).
- in_ready is 1 only in IDLE; in_valid in any other state is ignored.
- abort in any non-IDLE state (including DONE) -> IDLE next cycle; out_valid=0; any pending result is dropped. abort in IDLE has no effect.
- Input ports are sampled only at accept; changing them while busy has no effect.

Optional Feature:
- Macro MODEXP_CONST_TIME_EN.
- Defined:
  - SCAN is bypassed: REDUCE -> SQUARE with idx = WIDTH-1.
  - Every bit gets SQUARE then MULT; the MULT result is discarded when E[idx]==0.
  - Latency = WIDTH + 2*WIDTH*WIDTH + 1, independent of data.
- Not defined: the data-dependent flow and latency above.

Decomposition:
- Package rsa_pkg holds:
  - the state encoding localparams (IDLE..DONE);
  - the default WIDTH;
  - the helper function that computes IDXW.
- Sub-module modmul_serial, the WIDTH-cycle interleaved A*B mod N unit.
  - Interface: start, A, B, N, done pulse, product.
  - Instantiated once and shared by REDUCE, SQUARE and MULT.

Test Plan:
- WIDTH=16, M=8, E=13, N=77 -> result=50, error=0; out_valid at cycle 142 (macro off) / 529 (macro on).
- WIDTH=16, M=50, E=37, N=77 -> result=8 (decrypt round trip).
- E=0, N=77, M=5 -> result=1. N=1 -> result=0. M=200, E=1, N=77 -> result=46 (pre-reduction).
- N=0 -> out_valid at cycle 1, error=1, result=0. Hold out_ready=0 for 10 cycles: result stable, in_ready=0.
- Abort 20 cycles after accept -> busy=0 and in_ready=1 next cycle, no out_valid. Then 8^13 mod 77 -> 50.
- Drive reset=0 mid-SQUARE -> all outputs at reset values next edge. in_valid during busy is ignored.
